// File: rtl/hadder_pkg.sv
// Shared adder-side definitions: sample width and the accumulator FSM encoding.
// Both the adder datapath and its downstream consumers import this package.
package hadder_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sum_acc8_mod_n_counter.sv
// Modulo-N counter with sync clear/enable and terminal-count flag at N-1.
// Latency: count updates on the edge after en; tc is decoded from the count register.
// Backpressure: none, the caller gates en.
module mod_n_counter #(
    parameter int N     = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sum_acc8.sv
// Batch accumulator: sums N 8-bit samples and presents the total on a held output.
// Latency: SUM_VALID rises on the edge after the Nth accepted sample.
// Backpressure: D_READY only in ACC; DONE holds SUM until SUM_READY. SUM_ACC8_SATURATE_EN clamps and adds SAT.
module sum_acc8
    import hadder_pkg::*;
#(
    parameter int   N     = 4,
    parameter int   ACC_W = 10,
    localparam int  CNT_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] D,
    input  logic              D_VALID,
    output logic              D_READY,
    output logic [ACC_W-1:0]  SUM,
    output logic              SUM_VALID,
    input  logic              SUM_READY,
    output logic              BUSY,
`ifdef SUM_ACC8_SATURATE_EN
    output logic              SAT,
`endif
    output logic [CNT_W-1:0]  CNT
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             batch_start;
    logic             last;
    logic [ACC_W-1:0] sum_add;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        batch_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    batch_start = 1'b1;
                    state_nxt   = ST_ACC;
                end
            end
            ST_ACC: begin
                if (D_VALID) begin
                    accept = 1'b1;
                    if (last) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // START alone is ignored here; paired with SUM_READY it chains the next batch.
                if (SUM_READY) begin
                    if (START) begin
                        batch_start = 1'b1;
                        state_nxt   = ST_ACC;
                    end else begin
                        state_nxt   = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign D_READY   = (state == ST_ACC);
    assign SUM_VALID = (state == ST_DONE);
    assign BUSY      = (state != ST_IDLE);

    mod_n_counter #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (CLK),
        .rst (RST),
        .clr (batch_start),
        .en  (accept),
        .cnt (CNT),
        .tc  (last)
    );

`ifdef SUM_ACC8_SATURATE_EN
    logic [ACC_W:0] sum_ext;
    logic           clamp;

    // One guard bit is enough: a single 8-bit addend can overflow at most once.
    assign sum_ext = {1'b0, SUM} + (ACC_W + 1)'(D);
    assign clamp   = sum_ext[ACC_W];
    assign sum_add = clamp ? '1 : sum_ext[ACC_W-1:0];

    always_ff @(posedge CLK) begin
        if (RST || batch_start) begin
            SAT <= 1'b0;
        end else if (accept && clamp) begin
            SAT <= 1'b1;
        end
    end
`else
    assign sum_add = SUM + ACC_W'(D);
`endif

    always_ff @(posedge CLK) begin
        if (RST || batch_start) begin
            SUM <= '0;
        end else if (accept) begin
            SUM <= sum_add;
        end
    end

endmodule

// File: tb/tb_sum_acc8.sv
// Bench for sum_acc8: random/directed batches checked against an arithmetic batch-sum model.
// A second instance (N=2, ACC_W=8) covers wrap or clamp depending on SUM_ACC8_SATURATE_EN.
module tb_sum_acc8;

    localparam int N  = 4;
    localparam int W  = 10;
    localparam int N2 = 2;
    localparam int W2 = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   d;
    logic         d_valid;
    logic         d_ready;
    logic [W-1:0] sum;
    logic         sum_valid;
    logic         sum_ready;
    logic         busy;
    logic [1:0]   cnt;

    logic          w_start;
    logic [7:0]    w_d;
    logic          w_d_valid;
    logic          w_d_ready;
    logic [W2-1:0] w_sum;
    logic          w_sum_valid;
    logic          w_sum_ready;
    logic          w_busy;
    logic [0:0]    w_cnt;

`ifdef SUM_ACC8_SATURATE_EN
    logic sat;
    logic w_sat;
`endif

    int errs   = 0;
    int checks = 0;

    logic [7:0] dir_q[$];
    logic [7:0] a_reg = 8'd0;
    logic [7:0] b_reg = 8'd0;

    always #5 clk = ~clk;

    sum_acc8 #(.N(N), .ACC_W(W)) u_dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .D         (d),
        .D_VALID   (d_valid),
        .D_READY   (d_ready),
        .SUM       (sum),
        .SUM_VALID (sum_valid),
        .SUM_READY (sum_ready),
        .BUSY      (busy),
`ifdef SUM_ACC8_SATURATE_EN
        .SAT       (sat),
`endif
        .CNT       (cnt)
    );

    sum_acc8 #(.N(N2), .ACC_W(W2)) u_dut_w (
        .CLK       (clk),
        .RST       (rst),
        .START     (w_start),
        .D         (w_d),
        .D_VALID   (w_d_valid),
        .D_READY   (w_d_ready),
        .SUM       (w_sum),
        .SUM_VALID (w_sum_valid),
        .SUM_READY (w_sum_ready),
        .BUSY      (w_busy),
`ifdef SUM_ACC8_SATURATE_EN
        .SAT       (w_sat),
`endif
        .CNT       (w_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected batch total from the plain arithmetic sum of accepted samples.
    function automatic longint ref_total(input longint raw, input int w);
        longint max_v;
        max_v = (longint'(1) << w) - 1;
`ifdef SUM_ACC8_SATURATE_EN
        return (raw > max_v) ? max_v : raw;
`else
        return raw % (max_v + 1);
`endif
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rdy_after_start", d_ready, 1);
        check("sum_clr_start", sum, 0);
        check("cnt_clr_start", cnt, 0);
    endtask

    // mode: 0 rand/continuous, 1 rand/alternating valid, 2 rand/random gaps, 3 dir_q, 4 adder-fed
    task automatic feed(input int mode, input int stop_at, output longint total);
        int         got  = 0;
        int         cyc  = 0;
        bit         have = 1'b0;
        bit         v;
        logic [7:0] cur  = 8'd0;
        total = 0;
        while (got < stop_at && cyc < 200) begin
            check("cnt_run", cnt, got);
            case (mode)
                1:       v = (cyc % 2 == 0);
                2:       v = ($urandom_range(0, 2) != 0);
                default: v = 1'b1;
            endcase
            if (mode == 4) begin
                a_reg = a_reg + 8'd50;
                if (cyc % 2 == 0) b_reg = b_reg + 8'd37;
                cur  = a_reg + b_reg;
                have = 1'b1;
            end else if (!have) begin
                cur  = (mode == 3) ? dir_q.pop_front() : 8'($urandom);
                have = 1'b1;
            end
            d       = cur;
            d_valid = v;
            if (v && d_ready) begin
                total += longint'(cur);
                got++;
                if (mode != 4) have = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        d_valid = 1'b0;
        if (cyc >= 200) check("feed_timeout", got, stop_at);
        if (stop_at == N) begin
            check("sum_valid_done", sum_valid, 1);
            check("sum_done", sum, ref_total(total, W));
            check("rdy_done", d_ready, 0);
            check("cnt_done", cnt, 0);
            check("busy_done", busy, 1);
`ifdef SUM_ACC8_SATURATE_EN
            check("sat_main", sat, (total > longint'((1 << W) - 1)));
`endif
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sv"}, sum_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cnt"}, cnt, 0);
        check({tag, "_rdy"}, d_ready, 0);
    endtask

    task automatic wrap_batch(input logic [7:0] s0, input logic [7:0] s1, input bit exp_sat);
        @(negedge clk);
        w_start = 1'b1;
        @(negedge clk);
        w_start   = 1'b0;
        check("w_rdy_start", w_d_ready, 1);
        w_d       = s0;
        w_d_valid = 1'b1;
        @(negedge clk);
        check("w_cnt_one", w_cnt, 1);
        w_d = s1;
        @(negedge clk);
        w_d_valid = 1'b0;
        check("w_sum_valid", w_sum_valid, 1);
        check("w_sum", w_sum, ref_total(longint'(s0) + longint'(s1), W2));
`ifdef SUM_ACC8_SATURATE_EN
        check("w_sat", w_sat, exp_sat);
`else
        check("w_nosat_ref", w_sum, (longint'(s0) + longint'(s1)) % 256 + (exp_sat ? 0 : 0));
`endif
        @(negedge clk);
        check("w_sv_drop", w_sum_valid, 0);
    endtask

    initial begin
        longint tot;
        longint exp_sum;
        rst         = 1'b1;
        start       = 1'b0;
        d           = 8'd0;
        d_valid     = 1'b0;
        sum_ready   = 1'b0;
        w_start     = 1'b0;
        w_d         = 8'd0;
        w_d_valid   = 1'b0;
        w_sum_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_sum", sum, 0);
        check_idle("rst");
        rst = 1'b0;

        // Basic batch 10+20+30+40
        sum_ready = 1'b1;
        dir_q = '{8'd10, 8'd20, 8'd30, 8'd40};
        do_start();
        feed(3, N, tot);
        check("basic_sum", sum, 100);
        @(negedge clk);
        check_idle("basic_end");

        // All-max samples: 1020 fits in 10 bits
        dir_q = '{8'd255, 8'd255, 8'd255, 8'd255};
        do_start();
        feed(3, N, tot);
        check("max_sum", sum, 1020);
        @(negedge clk);
        check_idle("max_end");

        // Random batches, continuous and gappy
        for (int i = 0; i < 6; i++) begin
            do_start();
            feed((i % 2 == 0) ? 0 : 2, N, tot);
            @(negedge clk);
            check("rand_end_sv", sum_valid, 0);
        end

        // Handshake stress: alternating valid, then consumer stalls in DONE
        sum_ready = 1'b0;
        do_start();
        feed(1, N, tot);
        exp_sum = ref_total(tot, W);
        for (int i = 0; i < 5; i++) begin
            check("stall_rdy", d_ready, 0);
            check("stall_sum", sum, exp_sum);
            check("stall_sv", sum_valid, 1);
            start = (i == 2);
            @(negedge clk);
        end
        start     = 1'b1;
        sum_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        sum_ready = 1'b0;
        check("b2b_rdy", d_ready, 1);
        check("b2b_sum", sum, 0);
        check("b2b_sv", sum_valid, 0);
        check("b2b_cnt", cnt, 0);
        feed(2, N, tot);
        sum_ready = 1'b1;
        @(negedge clk);
        check_idle("b2b_end");

        // Adder-fed stream: D follows O = A + B with A += 50 per cycle, B += 37 every two
        a_reg = 8'd0;
        b_reg = 8'd0;
        do_start();
        feed(4, N, tot);
        @(negedge clk);
        check_idle("adder_end");

        // Reset in the middle of a batch
        do_start();
        feed(2, 2, tot);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_sum", sum, 0);
        check_idle("midrst");
        do_start();
        feed(0, N, tot);
        @(negedge clk);
        check_idle("post_rst_end");

        // Narrow instance: 200+100 wraps to 44 or clamps to 255; next batch clears SAT
        wrap_batch(8'd200, 8'd100, 1'b1);
        wrap_batch(8'd1, 8'd2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
